// File: rtl/expr_recognizer_if.sv
// Character-stream bundle for the expression recognizer.
// Source drives in_valid/in; recognizer returns status.
interface expr_recognizer_if #(
  parameter int DEPTH_W = 3,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   opnd_cnt;

  modport master (
    output in_valid, in,
    input  out, err, depth, opnd_cnt
  );

  modport slave (
    input  in_valid, in,
    output out, err, depth, opnd_cnt
  );
endinterface

// File: rtl/expr_recognizer.sv
// Serial ASCII arithmetic-expression recognizer.
// Optional WS_SKIP_EN: ignore space and tab in every state.
module expr_recognizer #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int DEPTH_W    = 3,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic clr,
  expr_recognizer_if.slave bus
);

  typedef enum logic [1:0] {
    S_OPND,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_e;

  localparam int DIG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DIG_W-1:0]   DIG_MAX = DIG_W'(MAX_DIGITS);
  localparam logic [DEPTH_W-1:0] DEP_MAX = DEPTH_W'(MAX_DEPTH);

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   dcnt_q, dcnt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               err_q, err_d;

  logic [7:0] ch;
  logic       is_dig;
  logic       is_op;
  logic       is_lp;
  logic       is_rp;
  logic       is_ws;
  logic       bad;

  assign ch     = bus.in;
  assign is_dig = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_op  = (ch == 8'h2b) || (ch == 8'h2d) ||
                  (ch == 8'h2a) || (ch == 8'h2f);
  assign is_lp  = (ch == 8'h28);
  assign is_rp  = (ch == 8'h29);

`ifdef WS_SKIP_EN
  assign is_ws = (ch == 8'h20) || (ch == 8'h09);
`else
  assign is_ws = 1'b0;
`endif

  // Next state, counters and status for one accepted character.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    bad     = 1'b0;

    if (bus.in_valid && (state_q != S_ERR) && !is_ws) begin
      unique case (state_q)
        S_OPND: begin
          unique case (1'b1)
            is_dig: begin
              state_d = S_NUM;
              dcnt_d  = DIG_W'(1);
              cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            end
            is_lp: begin
              if (depth_q < DEP_MAX)
                depth_d = depth_q + DEPTH_W'(1);
              else
                bad = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
        S_NUM: begin
          unique case (1'b1)
            is_dig: begin
              if (dcnt_q < DIG_MAX)
                dcnt_d = dcnt_q + DIG_W'(1);
              else
                bad = 1'b1;
            end
            is_op: state_d = S_OPND;
            is_rp: begin
              if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
                state_d = S_CLOSE;
              end else begin
                bad = 1'b1;
              end
            end
            default: bad = 1'b1;
          endcase
        end
        S_CLOSE: begin
          unique case (1'b1)
            is_op: state_d = S_OPND;
            is_rp: begin
              if (depth_q != '0)
                depth_d = depth_q - DEPTH_W'(1);
              else
                bad = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
        default: ;
      endcase

      if (bad) begin
        state_d = S_ERR;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        err_d   = 1'b1;
      end else begin
        out_d = ((state_d == S_NUM) || (state_d == S_CLOSE))
                && (depth_d == '0);
      end
    end
  end

  // State and registered outputs; clr clears immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_OPND;
      dcnt_q  <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.err      = err_q;
  assign bus.depth    = depth_q;
  assign bus.opnd_cnt = cnt_q;

endmodule
